// File: rtl/mem_pkg.sv
// Shared encodings for the CPU-side memory access unit: request sizes,
// FSM states and the default read latency of the memory controller.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int unsigned MEM_LAT_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    // A request faults before touching memory if its size is reserved or
    // its address is not naturally aligned for that size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts a byte/half/word from a memory word
// with sign or zero extension, and merges store data into a memory word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output of this block gets a value before any case/if,
        // so no path can leave one unassigned and infer a latch.
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        load_o   = word_i;
        merge_o  = word_i;

        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
                merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_HALF: begin
                load_o = {{16{signed_i & half_sel[15]}}, half_sel};
                if (off_i[1]) begin
                    merge_o[31:16] = wdata_i[15:0];
                end else begin
                    merge_o[15:0] = wdata_i[15:0];
                end
            end
            default: begin
                load_o  = word_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Sequences one CPU load/store at a time onto the word-wide memory controller
// port, doing read-modify-write for sub-word stores and returning a response.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_error
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        op_write_q, op_write_d;
    logic [1:0]  op_size_q, op_size_d;
    logic        op_signed_q, op_signed_d;
    logic [31:0] op_addr_q, op_addr_d;
    logic [31:0] op_wdata_q, op_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    mem_lane_align u_lane_align (
        .word_i   (mem_rdata),
        .off_i    (op_addr_q[1:0]),
        .size_i   (op_size_q),
        .signed_i (op_signed_q),
        .wdata_i  (op_wdata_q),
        .load_o   (lane_load),
        .merge_o  (lane_merge)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        op_write_d  = op_write_q;
        op_size_d   = op_size_q;
        op_signed_d = op_signed_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_write_d  = req_write;
                    op_size_d   = req_size;
                    op_signed_d = req_signed;
                    op_addr_d   = req_addr;
                    op_wdata_d  = req_wdata;
                    cnt_d       = 3'(MEM_LAT);
                    first_d     = 1'b1;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d = ST_RESP;
                    end else if (!req_write || req_size != SZ_WORD) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end

            // First RD cycle presents the address; the countdown then covers
            // the controller's read latency before data is sampled.
            ST_RD: begin
                if (first_q) begin
                    first_d    = 1'b0;
                    mem_addr_d = {op_addr_q[31:2], 2'b00};
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (mem_error) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b1;
                    rsp_rdata_d = '0;
                end else if (!op_write_q) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b0;
                    rsp_rdata_d = lane_load;
                end else begin
                    state_d     = ST_WR;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = lane_merge;
                end
            end

            ST_WR: begin
                if (first_q) begin
                    first_d     = 1'b0;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {op_addr_q[31:2], 2'b00};
                    mem_wdata_d = op_wdata_q;
                end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = mem_error;
                    rsp_rdata_d = '0;
                end
            end

            // Entered with rsp_valid low only from the pre-check fault path.
            ST_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b1;
                    rsp_rdata_d = '0;
                end else if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_fault_d = 1'b0;
                    rsp_rdata_d = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of every other flop.
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            op_write_q  <= 1'b0;
            op_size_q   <= SZ_BYTE;
            op_signed_q <= 1'b0;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            op_write_q  <= op_write_d;
            op_size_q   <= op_size_d;
            op_signed_q <= op_signed_d;
            op_addr_q   <= op_addr_d;
            op_wdata_q  <= op_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a latency-accurate memory stand-in, a reference
// model of request outcomes and timing, and directed load/store vectors.
module tb_mem_access_unit;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_we, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] dev_mem   [256] = '{default: 32'h0};
    logic [31:0] model_mem [256] = '{default: 32'h0};
    logic [31:0] addr_hist [8]   = '{default: 32'h0};
    logic [31:0] rd_addr;
    logic        we_allowed = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_error  (mem_error)
    );

    // Memory stand-in: read data follows the address LAT cycles later;
    // addresses with bit 31 set decode to an error.
    always @(posedge clk) begin
        addr_hist[0] <= mem_addr;
        for (int i = 1; i < 8; i++) addr_hist[i] <= addr_hist[i-1];
        if (mem_we && !mem_addr[31]) dev_mem[mem_addr[9:2]] <= mem_wdata;
    end
    assign rd_addr   = (LAT == 0) ? mem_addr : addr_hist[(LAT == 0) ? 0 : LAT - 1];
    assign mem_rdata = rd_addr[31] ? 32'hBAD0_BAD0 : dev_mem[rd_addr[9:2]];
    assign mem_error = mem_we ? mem_addr[31] : rd_addr[31];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            check("we_allowed", 32'(we_allowed), 32'd1);
            check("mem_addr_align", 32'(mem_addr[1:0]), 32'd0);
        end
    end

    function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                               input logic [1:0] sz, input logic sg);
        longint v, span;
        int     sh;
        if (sz == 2'd2) return word;
        span = (sz == 2'd0) ? 256 : 65536;
        sh   = 8 * int'(a % 4);
        v    = longint'(word >> sh) % span;
        if (sg && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [31:0] a,
                                                input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int          sh;
        if (sz == 2'd2) return wd;
        mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        sh   = 8 * int'(a % 4);
        return (word & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic send(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input int hold,
                        output logic [31:0] got_rdata, output logic got_fault);
        logic        f, err, ef;
        logic [31:0] er;
        int          k, we_exp, we_seen, we_at, n, idx;
        idx = int'(a[9:2]);
        err = a[31];
        f   = model_fault(sz, a);
        if (f) begin
            k = 1; we_exp = -1; ef = 1'b1; er = 32'h0;
        end else if (!wr) begin
            k = LAT + 2; we_exp = -1; ef = err;
            er = err ? 32'h0 : model_load(model_mem[idx], a, sz, sg);
        end else if (sz == 2'd2) begin
            k = 2; we_exp = 1; ef = err; er = 32'h0;
        end else if (err) begin
            k = LAT + 2; we_exp = -1; ef = 1'b1; er = 32'h0;
        end else begin
            k = LAT + 3; we_exp = LAT + 2; ef = 1'b0; er = 32'h0;
        end
        if (wr && !f && !err) model_mem[idx] = model_merge(model_mem[idx], a, sz, wd);
        we_allowed = (we_exp >= 0);

        req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;

        we_seen = 0; we_at = -1; n = 0;
        while (n < 40 && !rsp_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (mem_we) begin
                we_seen++;
                we_at = n;
            end
            check("req_ready_busy", 32'(req_ready), 32'd0);
        end
        check("rsp_latency", 32'(n), 32'(k));
        check("we_count", 32'(we_seen), (we_exp >= 0) ? 32'd1 : 32'd0);
        check("we_cycle", 32'(we_at), 32'(we_exp));
        check("rsp_rdata", rsp_rdata, er);
        check("rsp_fault", 32'(rsp_fault), 32'(ef));
        got_rdata = rsp_rdata;
        got_fault = rsp_fault;

        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, er);
            check("hold_fault", 32'(rsp_fault), 32'(ef));
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_no_we", 32'(mem_we), 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("rsp_cleared", {30'd0, rsp_valid, rsp_fault}, 32'd0);
        check("rsp_rdata_cleared", rsp_rdata, 32'h0);
        check("req_ready_after", 32'(req_ready), 32'd1);
        we_allowed = 1'b0;
        if (wr) check("mem_word", dev_mem[idx], model_mem[idx]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        flt;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_rsp", {30'd0, rsp_valid, rsp_fault}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Word store then word load.
        send(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 0, rd, flt);
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, rd, flt);
        check("lit_word_load", rd, 32'hDEADBEEF);
        check("lit_word_fault", 32'(flt), 32'd0);

        // Byte RMW and extension.
        send(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 0, rd, flt);
        send(1'b1, 2'd0, 1'b0, 32'h102, 32'h00000080, 0, rd, flt);
        check("lit_rmw_word", dev_mem[32'h100 >> 2], 32'h11803344);
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, rd, flt);
        check("lit_rmw_load", rd, 32'h11803344);
        send(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 0, rd, flt);
        check("lit_byte_signed", rd, 32'hFFFFFF80);
        send(1'b0, 2'd0, 1'b0, 32'h102, 32'h0, 0, rd, flt);
        check("lit_byte_unsigned", rd, 32'h00000080);

        // Halfword RMW, half loads and remaining byte lanes.
        send(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 0, rd, flt);
        send(1'b1, 2'd1, 1'b0, 32'h106, 32'hFFFF1234, 0, rd, flt);
        check("lit_half_rmw", dev_mem[32'h104 >> 2], 32'h1234F00D);
        send(1'b0, 2'd1, 1'b1, 32'h104, 32'h0, 0, rd, flt);
        check("lit_half_signed", rd, 32'hFFFFF00D);
        send(1'b0, 2'd1, 1'b1, 32'h106, 32'h0, 0, rd, flt);
        send(1'b0, 2'd1, 1'b0, 32'h104, 32'h0, 0, rd, flt);
        send(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 0, rd, flt);
        send(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 0, rd, flt);
        send(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, rd, flt);
        send(1'b1, 2'd0, 1'b0, 32'h107, 32'hAB, 0, rd, flt);
        send(1'b1, 2'd0, 1'b0, 32'h104, 32'h5A, 0, rd, flt);

        // Pre-check faults.
        send(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0, rd, flt);
        check("lit_fault_half", 32'(flt), 32'd1);
        send(1'b1, 2'd2, 1'b0, 32'h102, 32'h55555555, 0, rd, flt);
        check("lit_fault_word", 32'(flt), 32'd1);
        send(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 0, rd, flt);
        check("lit_fault_rsvd", 32'(flt), 32'd1);

        // Memory error responses.
        send(1'b0, 2'd2, 1'b0, 32'h8000_0100, 32'h0, 0, rd, flt);
        check("lit_err_load_fault", 32'(flt), 32'd1);
        check("lit_err_load_data", rd, 32'h0);
        send(1'b1, 2'd0, 1'b0, 32'h8000_0101, 32'h77, 0, rd, flt);
        check("lit_err_rmw_fault", 32'(flt), 32'd1);
        send(1'b1, 2'd2, 1'b0, 32'h8000_0100, 32'h1, 0, rd, flt);
        check("lit_err_store_fault", 32'(flt), 32'd1);

        // Response back-pressure, then an immediate follow-on request.
        send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5, rd, flt);
        send(1'b0, 2'd0, 1'b1, 32'h106, 32'h0, 0, rd, flt);

        // Reset during the read phase of a halfword RMW.
        we_allowed = 1'b0;
        req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h104; req_wdata = 32'h0000AAAA; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_we", 32'(mem_we), 32'd0);
        check("rst_mid_rsp", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("rst_mid_quiet", {30'd0, mem_we, rsp_valid}, 32'd0);
        end
        check("rst_mid_mem", dev_mem[32'h104 >> 2], model_mem[32'h104 >> 2]);

        for (int i = 0; i < 256; i++) check("final_mem", dev_mem[i], model_mem[i]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequencing stage between the CPU pipeline and `memory_controller`. Accepts one load or store request at a time over a valid/ready handshake and checks alignment. Drives the controller's word-wide `cpu_write_mem`/`addr`/`idata_from_cpu` port, performing read-modify-write for byte and halfword stores. Returns sign- or zero-extended load data, or a fault, over a valid/ready response channel.

## Interface
- `MEM_LAT`, 1: cycles between presenting a read address and `mem_rdata`/`mem_error` being valid; legal range 0–7.
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  CPU request present.
- `req_ready`  out  1  unit can accept a request; equals (state == IDLE).
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_signed`  in  1  sign-extend load data; ignored for stores and word loads.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  CPU accepts response.
- `rsp_rdata`  out  32  load result; 0 for stores and faults.
- `rsp_fault`  out  1  misaligned, reserved size, or memory error.
- `mem_we`  out  1  to `cpu_write_mem`; 0 = read.
- `mem_addr`  out  32  to `addr`; always word-aligned, bits [1:0] = 0.
- `mem_wdata`  out  32  to `idata_from_cpu`.
- `mem_rdata`  in  32  from `odata_to_cpu`.
- `mem_error`  in  1  from `error`.

## Operation
- States: IDLE, RD, WR, RESP.
- All `mem_*` and `rsp_*` outputs are registered.
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_fault`=0, state=IDLE.
- IDLE: on `req_valid`, latch all request fields.
  - Fault check first. Half with addr[0]=1, word with addr[1:0]≠0, or size 11 → RESP with fault=1. No memory access is made.
  - Load → RD.
  - Word store → WR.
  - Byte/half store → RD (RMW).
- RD: `mem_we`=0, `mem_addr`={addr[31:2],2'b00}.
  - A 3-bit counter loads `MEM_LAT` on entry and decrements each cycle.
  - When the counter is 0, sample `mem_rdata` and `mem_error`.
  - Error → RESP, fault=1.
  - Load → RESP with extracted lane.
  - RMW → WR with merged word.
- Lane extract (little-endian): byte lane = addr[1:0]; half lane = addr[1]. Zero-extend, or sign-extend from bit 7/15 when `req_signed`=1.
- Lane merge: replace only the addressed byte/half of the read word with `req_wdata[7:0]`/`[15:0]`; the other bytes are preserved.
- WR: `mem_we`=1 for exactly one cycle with the aligned address and word data.
  - Sample `mem_error` in that cycle → RESP, with fault equal to the sampled `mem_error`.
  - `mem_we` returns to 0 on the cycle after WR.
- RESP: hold `rsp_valid`=1 and stable data until `rsp_ready`, then go to IDLE. `rsp_*` are cleared on the leaving edge.
- Outside WR, `mem_we` stays 0, so the controller sees reads only.
- `mem_addr` holds its last value in IDLE and RESP.
- `rsp_ready` asserted early (before `rsp_valid`) has no effect.

## Timing
- The request handshake completes at edge T.
- Load: `rsp_valid` rises at T+MEM_LAT+2 (T+3 with default `MEM_LAT`).
- Word store: `mem_we`=1 during cycle T+1; `rsp_valid` rises at T+2.
- Sub-word store: read at T+1..T+1+MEM_LAT; `mem_we`=1 at T+2+MEM_LAT; `rsp_valid` rises at T+3+MEM_LAT.
- Fault pre-check: `rsp_valid` rises at T+1.
- Back-to-back: a new request can be accepted the cycle after a response handshake. No overlap between requests; throughput is one request per (latency+1) cycles minimum.
- Reset mid-operation: the operation is aborted with no response. `mem_we` is 0 from the next cycle, so a partial RMW never writes.
- `rsp_ready` held low stalls in RESP indefinitely, with no memory activity.

## Structure
- Package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - state encoding;
  - `MEM_LAT` default.
- Sub-module `mem_lane_align` (combinational): lane extract with sign/zero extend, and lane merge. Instantiated once, shared by the load and RMW paths.
- The FSM and counter stay in `mem_access_unit`.

## Test plan
- Word store 0xDEADBEEF @0x100, then word load @0x100 → `rsp_rdata`=0xDEADBEEF, fault=0, `rsp_valid` at T+3.
- Byte store 0x80 @0x102 over 0x11223344, then signed byte load @0x102 → memory word 0x11803344, load returns 0xFFFFFF80; unsigned returns 0x00000080.
- Half load @0x101, word store @0x102, size=11 → each returns fault=1 at T+1, and `mem_we` never asserts.
- Address decoding to `mem_error`=1 on read → fault=1, `rsp_rdata`=0. A sub-word store to the same address never asserts `mem_we`.
- Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/data stable and `req_ready`=0. Then accept and issue a new request the next cycle.
- Assert `rst` during the RD state of a halfword store → no `mem_we` pulse, no response, `req_ready`=1 after reset.
